// File: rtl/vga_timing_gen_if.sv
// Raster/pixel bundle between the VGA timing generator and its neighbours.
// The master side is the timing generator: it takes the run enable and the
// colour returned by the graphics stage, and drives counters and pin outputs.
interface vga_timing_gen_if;
  logic       en;
  logic [7:0] pix_color;
  logic [9:0] hc;
  logic [9:0] vc;
  logic       pix_tick;
  logic       active;
  logic       frame_start;
  logic       hsync;
  logic       vsync;
  logic [2:0] vga_r;
  logic [2:0] vga_g;
  logic [1:0] vga_b;

  modport master (
    input  en, pix_color,
    output hc, vc, pix_tick, active, frame_start, hsync, vsync, vga_r, vga_g, vga_b
  );

  modport slave (
    output en, pix_color,
    input  hc, vc, pix_tick, active, frame_start, hsync, vsync, vga_r, vga_g, vga_b
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with a programmable pixel-clock divider and a
// registered pin stage. hc/vc lead the pins by one pixel period so the
// graphics stage can answer combinationally; colour, syncs and active are
// captured together on the pixel tick and therefore stay aligned.
// H_TOTAL-1 and V_TOTAL-1 must fit in 10 bits.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic               clk,
  input  logic               reset_n,
  vga_timing_gen_if.master   io_vga
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam bit         SYNC_OFF = ~SYNC_POL;

  logic [DIV_W-1:0] r_div;
  logic             r_pix_tick;
  logic [9:0]       r_hc;
  logic [9:0]       r_vc;
  logic             r_active;
  logic             r_frame_start;
  logic             r_hsync;
  logic             r_vsync;
  logic [7:0]       r_rgb;

  logic [DIV_W-1:0] w_div_nxt;
  logic             w_tick_nxt;
  logic [9:0]       w_hc_nxt;
  logic [9:0]       w_vc_nxt;
  logic             w_vis;
  logic             w_hs_on;
  logic             w_vs_on;

  // Divider: tick is registered, so it is predicted from the next div value.
  always_comb begin
    w_div_nxt  = (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
    w_tick_nxt = (w_div_nxt == DIV_LAST);
  end

  // Raster counters step once per pixel period.
  always_comb begin
    w_hc_nxt = r_hc;
    w_vc_nxt = r_vc;
    if (r_pix_tick) begin
      if (r_hc == H_LAST) begin
        w_hc_nxt = '0;
        w_vc_nxt = (r_vc == V_LAST) ? '0 : r_vc + 10'd1;
      end else begin
        w_hc_nxt = r_hc + 10'd1;
      end
    end
  end

  // Decode of the pixel currently addressed by hc/vc.
  always_comb begin
    w_vis   = (r_hc < H_VIS) && (r_vc < V_VIS);
    w_hs_on = (r_hc >= HS_START) && (r_hc < HS_END);
    w_vs_on = (r_vc >= VS_START) && (r_vc < VS_END);
  end

  // State and pin stage; en=0 reloads the reset image synchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div         <= '0;
      r_pix_tick    <= 1'b0;
      r_hc          <= '0;
      r_vc          <= '0;
      r_active      <= 1'b0;
      r_frame_start <= 1'b0;
      r_hsync       <= SYNC_OFF;
      r_vsync       <= SYNC_OFF;
      r_rgb         <= '0;
    end else if (!io_vga.en) begin
      r_div         <= '0;
      r_pix_tick    <= 1'b0;
      r_hc          <= '0;
      r_vc          <= '0;
      r_active      <= 1'b0;
      r_frame_start <= 1'b0;
      r_hsync       <= SYNC_OFF;
      r_vsync       <= SYNC_OFF;
      r_rgb         <= '0;
    end else begin
      r_div         <= w_div_nxt;
      r_pix_tick    <= w_tick_nxt;
      r_hc          <= w_hc_nxt;
      r_vc          <= w_vc_nxt;
      // Pulses for one clk right after pixel (0,0) is captured to the pins.
      r_frame_start <= r_pix_tick && (r_hc == '0) && (r_vc == '0);
      if (r_pix_tick) begin
        r_active <= w_vis;
        r_rgb    <= w_vis ? io_vga.pix_color : 8'h00;
        r_hsync  <= w_hs_on ? SYNC_POL : SYNC_OFF;
        r_vsync  <= w_vs_on ? SYNC_POL : SYNC_OFF;
      end
    end
  end

  assign io_vga.hc          = r_hc;
  assign io_vga.vc          = r_vc;
  assign io_vga.pix_tick    = r_pix_tick;
  assign io_vga.active      = r_active;
  assign io_vga.frame_start = r_frame_start;
  assign io_vga.hsync       = r_hsync;
  assign io_vga.vsync       = r_vsync;
  assign io_vga.vga_r       = r_rgb[7:5];
  assign io_vga.vga_g       = r_rgb[4:2];
  assign io_vga.vga_b       = r_rgb[1:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size 640x480 instance (CLK_DIV=4) and a
// shrunken 16x11 raster (CLK_DIV=2) so whole frames fit in a short run.
// The driver pushes the expected outputs for every clock edge into a queue
// per instance; a monitor pops and compares just after each edge.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] hc;
    logic [9:0] vc;
    logic       tick;
    logic       active;
    logic       fs;
    logic       hs;
    logic       vs;
    logic [7:0] rgb;
  } exp_t;

  logic clk;
  logic reset_n;
  logic en;
  bit   mode;
  bit   cnt_en;
  int   e;
  int   n_checks;
  int   n_pass;
  int   hs_low_a;
  int   vs_low_b;
  int   fs_b;
  exp_t qa[$];
  exp_t qb[$];

  vga_timing_gen_if ifa ();
  vga_timing_gen_if ifb ();

  // Graphics-stage stand-in: colour is a fixed function of the raster position.
  function automatic logic [7:0] gfx(input logic [9:0] h, input logic [9:0] v);
    return {h[2:0], v[2:0], h[4:3]} ^ 8'h5A;
  endfunction

  assign ifa.en        = en;
  assign ifb.en        = en;
  assign ifa.pix_color = mode ? gfx(ifa.hc, ifa.vc) : 8'hE0;
  assign ifb.pix_color = mode ? gfx(ifb.hc, ifb.vc) : 8'hE0;

  vga_timing_gen #(
    .CLK_DIV(4)
  ) u_dut_a (
    .clk    (clk),
    .reset_n(reset_n),
    .io_vga (ifa.master)
  );

  vga_timing_gen #(
    .CLK_DIV (2),
    .H_ACTIVE(8),
    .H_FP    (2),
    .H_SYNC  (3),
    .H_BP    (3),
    .V_ACTIVE(6),
    .V_FP    (1),
    .V_SYNC  (2),
    .V_BP    (2),
    .SYNC_POL(1'b0)
  ) u_dut_b (
    .clk    (clk),
    .reset_n(reset_n),
    .io_vga (ifb.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs after the e-th enabled edge since the last restart.
  function automatic exp_t model(input int ee, input int d, input int ha, input int hf,
                                 input int hsw, input int hb, input int va, input int vf,
                                 input int vsw, input int vb, input bit md);
    int   ht, vt, n, p, q, qh, qv;
    bit   vis;
    exp_t r;
    ht     = ha + hf + hsw + hb;
    vt     = va + vf + vsw + vb;
    n      = ee / d;
    r      = '0;
    r.hs   = 1'b1;
    r.vs   = 1'b1;
    r.tick = (ee > 0) && (ee % d == d - 1);
    if (n > 0) begin
      p        = n % (ht * vt);
      r.hc     = 10'(p % ht);
      r.vc     = 10'(p / ht);
      q        = (n - 1) % (ht * vt);
      qh       = q % ht;
      qv       = q / ht;
      vis      = (qh < ha) && (qv < va);
      r.active = vis;
      r.rgb    = vis ? (md ? gfx(10'(qh), 10'(qv)) : 8'hE0) : 8'h00;
      r.hs     = !((qh >= ha + hf) && (qh < ha + hf + hsw));
      r.vs     = !((qv >= va + vf) && (qv < va + vf + vsw));
      r.fs     = (ee % d == 0) && (q == 0);
    end
    return r;
  endfunction

  function automatic exp_t model_a(input int ee);
    return model(ee, 4, 640, 16, 96, 48, 480, 10, 2, 33, mode);
  endfunction

  function automatic exp_t model_b(input int ee);
    return model(ee, 2, 8, 2, 3, 3, 6, 1, 2, 2, mode);
  endfunction

  function automatic string fmt(input exp_t x);
    return $sformatf("hc=%0d vc=%0d tick=%b active=%b fs=%b hs=%b vs=%b rgb=%h",
                     x.hc, x.vc, x.tick, x.active, x.fs, x.hs, x.vs, x.rgb);
  endfunction

  task automatic check(input string name, input exp_t act, input exp_t want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s t=%0t got {%s} want {%s}", name, $time, fmt(act), fmt(want));
  endtask

  task automatic check_int(input string name, input int act, input int want);
    n_checks++;
    if (act == want) n_pass++;
    else $display("FAIL %s got %0d want %0d", name, act, want);
  endtask

  function automatic exp_t obs_a();
    return '{ifa.hc, ifa.vc, ifa.pix_tick, ifa.active, ifa.frame_start, ifa.hsync,
             ifa.vsync, {ifa.vga_r, ifa.vga_g, ifa.vga_b}};
  endfunction

  function automatic exp_t obs_b();
    return '{ifb.hc, ifb.vc, ifb.pix_tick, ifb.active, ifb.frame_start, ifb.hsync,
             ifb.vsync, {ifb.vga_r, ifb.vga_g, ifb.vga_b}};
  endfunction

  // Drive inputs for the coming edge and queue what both DUTs should show after it.
  task automatic step(input logic rn, input logic en_v);
    @(negedge clk);
    reset_n = rn;
    en      = en_v;
    if (!rn || !en_v) e = 0;
    else e++;
    qa.push_back(model_a(e));
    qb.push_back(model_b(e));
  endtask

  task automatic run(input int n, input logic rn, input logic en_v);
    repeat (n) step(rn, en_v);
  endtask

  // Monitor: compare just after each active edge and gather pulse statistics.
  always @(posedge clk) begin
    #1;
    if (qa.size() > 0) check("dut_a", obs_a(), qa.pop_front());
    if (qb.size() > 0) check("dut_b", obs_b(), qb.pop_front());
    if (cnt_en) begin
      if (ifa.hsync == 1'b0) hs_low_a++;
      if (ifb.vsync == 1'b0) vs_low_b++;
      if (ifb.frame_start == 1'b1) fs_b++;
    end
  end

  initial begin
    reset_n  = 1'b0;
    en       = 1'b1;
    mode     = 1'b0;
    cnt_en   = 1'b0;
    e        = 0;
    n_checks = 0;
    n_pass   = 0;
    hs_low_a = 0;
    vs_low_b = 0;
    fs_b     = 0;

    // Held in reset, then run with a constant red input.
    run(3, 1'b0, 1'b1);
    cnt_en = 1'b1;
    run(3700, 1'b1, 1'b1);

    // Synchronous hold mid-frame; switch to the patterned colour while held.
    run(1, 1'b1, 1'b0);
    cnt_en = 1'b0;
    mode   = 1'b1;
    run(4, 1'b1, 1'b0);
    run(1300, 1'b1, 1'b1);

    // Asynchronous reset mid-line: outputs must clear before any clock edge.
    step(1'b0, 1'b1);
    #1;
    check("async_reset_a", obs_a(), model_a(0));
    check("async_reset_b", obs_b(), model_b(0));
    run(2, 1'b0, 1'b1);
    run(1300, 1'b1, 1'b1);

    // Same restart through en=0, then resume.
    run(3, 1'b1, 1'b0);
    run(400, 1'b1, 1'b1);

    @(posedge clk);
    #2;
    // Line 0 hsync: 96 pixels * 4 clks; small raster: 10 vsync windows, 11 frames.
    check_int("hsync_low_clks_a", hs_low_a, 384);
    check_int("vsync_low_clks_b", vs_low_b, 640);
    check_int("frame_start_count_b", fs_b, 11);
    check_int("queues_drained", qa.size() + qb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Upstream/downstream neighbour of the tile-graphics stage. It generates the 640x480@60 VGA raster counters hc and vc, which feed the graphics stage.
- It takes the 8-bit RRRGGGBB colour that the graphics stage returns combinationally for the current hc/vc.
- It registers that colour together with hsync/vsync into the pin-facing output stage, so pixels and syncs leave the block time-aligned.
- A programmable clock divider derives the pixel rate from the system clock.

Parameters:
- CLK_DIV, 4: system clocks per pixel (1..16); 100 MHz / 4 = 25 MHz pixel rate.
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: hsync width, in pixels.
- H_BP, 48: horizontal back porch; H_TOTAL = 800.
- V_ACTIVE, 480: visible lines.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vsync width, in lines.
- V_BP, 33: vertical back porch; V_TOTAL = 525.
- SYNC_POL, 0: sync asserted level (0 = active-low).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- en  in  1  raster run enable. Low = synchronous restart/hold.
- pix_color  in  8  colour from the graphics stage for the current hc/vc, RRRGGGBB.
- hc  out  10  horizontal counter, 0..H_TOTAL-1 (registered).
- vc  out  10  vertical counter, 0..V_TOTAL-1 (registered).
- pix_tick  out  1  one-clk strobe marking the last clk of each pixel period.
- active  out  1  registered; high while the pixel on the output pins is visible.
- frame_start  out  1  one-clk pulse when pixel (0,0) appears on the pins.
- hsync  out  1  registered horizontal sync.
- vsync  out  1  registered vertical sync.
- vga_r  out  3  registered red.
- vga_g  out  3  registered green.
- vga_b  out  2  registered blue.

Behaviour:
- Reset (async, reset_n=0):
  - div=0, hc=0, vc=0, pix_tick=0.
  - active=0, frame_start=0, vga_r/g/b=0.
  - hsync=vsync=~SYNC_POL (deasserted).
- en=0 (sampled on clk): same values as reset, loaded synchronously. Counting resumes from div=0 on the first clk with en=1.
- Divider:
  - div counts 0..CLK_DIV-1 and wraps.
  - pix_tick is a registered output, high for exactly the clk in which div==CLK_DIV-1.
  - With CLK_DIV=1, pix_tick is high every clk from the first enabled cycle after reset.
- Counters advance only on clk edges where pix_tick=1:
  - hc==H_TOTAL-1 → hc=0, and vc increments (vc==V_TOTAL-1 → vc=0).
  - Otherwise hc increments and vc holds.
- Decode (combinational, from current hc/vc):
  - vis = hc<H_ACTIVE && vc<V_ACTIVE.
  - hs_on = H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
  - vs_on = V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491.
- Output stage: on each pix_tick edge, in the same edge as the counter update:
  - {vga_r,vga_g,vga_b} <= vis ? pix_color : 0.
  - active <= vis.
  - hsync <= hs_on ? SYNC_POL : ~SYNC_POL.
  - vsync <= vs_on ? SYNC_POL : ~SYNC_POL.
  - Outputs hold between ticks.
- Latency: pins show pixel (h,v) one pixel period after hc/vc equalled (h,v). RGB, sync and active are mutually aligned.
- Blanking: pix_color is ignored whenever vis=0. RGB is forced to 0 outside the active area regardless of input.
- frame_start: registered, high for exactly one clk, the clk following the pix_tick edge that captured hc=0, vc=0. Not asserted during reset or en=0.
- Reset mid-frame: immediate return to reset values. The next frame starts at (0,0) with no partial sync pulse.
- Widths: H_TOTAL-1 and V_TOTAL-1 must fit in 10 bits; the parameter set violating this is illegal. Comparisons are unsigned.

Test Plan:
- Reset release, CLK_DIV=4, en=1 → first pix_tick on the 4th clk. hc=1 after it. hsync=vsync=1 and rgb=0 throughout line 0 blanking.
- pix_color=8'hE0 constant → vga_r=3'b111, g=0, b=0 for pin pixels 0..639 of lines 0..479. rgb=0 at pin pixels 640..799 and on lines 480..524.
- Line timing → hsync low for exactly 96 ticks (384 clks), starting at the tick after hc=656. Line period 800 ticks.
- Frame timing → vsync low for exactly 2 lines (1600 ticks), covering pin lines 490-491. frame_start pulses once every 420000 ticks (1,680,000 clks), always alongside active=1.
- Wrap check → at hc=799, vc=524, the next tick gives hc=0, vc=0, and frame_start pulses one clk later.
- Assert reset_n=0 at hc=300, vc=200, then release → all outputs at reset values immediately. Counting restarts at (0,0). Repeat with en=0 → identical result, applied synchronously.
